// File: rtl/mmio_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer_if
// Description : Address/strobe group of the CPU bus seen by mmio_timer.
//               The shared 64-bit data lines are a plain inout net on the
//               peripheral, so every agent can resolve the tristate directly.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_timer_if;
    logic [31:0] address;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;

    modport master (
        output address,
        output mem_write,
        output mem_read,
        output size
    );

    modport slave (
        input address,
        input mem_write,
        input mem_read,
        input size
    );
endinterface
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Memory-mapped free-running timer with CTRL / COUNT / COMPARE /
//               STATUS registers, compare-match and overflow flags for polling.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          ADDR_WIDTH = 8,
    parameter int          TIMER_SIZE = 32
) (
    input  wire logic   clock,
    input  wire logic   reset,
    mmio_timer_if.slave bus,
    inout  wire [63:0]  data
);

    // Registers sit on 8-byte boundaries, so the word index drops address[2:0].
    localparam int                    c_WORD_W      = ADDR_WIDTH - 3;
    localparam logic [c_WORD_W-1:0]   c_WORD_CTRL   = c_WORD_W'(0);
    localparam logic [c_WORD_W-1:0]   c_WORD_COUNT  = c_WORD_W'(1);
    localparam logic [c_WORD_W-1:0]   c_WORD_CMP    = c_WORD_W'(2);
    localparam logic [c_WORD_W-1:0]   c_WORD_STATUS = c_WORD_W'(3);
    localparam logic [TIMER_SIZE-1:0] c_COUNT_MAX   = '1;

    logic [2:0]            r_ctrl;      // {STOP_ON_MATCH, CLR_ON_MATCH, EN}
    logic [TIMER_SIZE-1:0] r_count;
    logic [TIMER_SIZE-1:0] r_compare;
    logic [1:0]            r_status;    // {OVF, MATCH}

    logic                  w_sel;
    logic                  w_wr;
    logic                  w_rd_drive;
    logic [c_WORD_W-1:0]   w_word;
    logic [63:0]           w_bmask;
    logic [63:0]           w_rdata;
    logic                  w_wr_ctrl;
    logic                  w_wr_count;
    logic                  w_wr_cmp;
    logic                  w_wr_status;
    logic                  w_cnt_active;
    logic                  w_match;
    logic                  w_count_max;
    logic [1:0]            w_hw_set;
    logic                  w_unused;

    // Byte-lane merge: only the lanes covered by the access size take new data.
    function automatic logic [63:0] f_merge(input logic [63:0] old_val,
                                            input logic [63:0] new_val,
                                            input logic [63:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    assign w_sel      = (bus.address[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign w_word     = bus.address[ADDR_WIDTH-1:3];
    assign w_wr       = w_sel & bus.mem_write;
    // A write always wins over a read so the peripheral never fights the CPU.
    assign w_rd_drive = w_sel & bus.mem_read & ~bus.mem_write;
    assign w_unused   = &{1'b0, bus.address[2:0]};

    assign w_wr_ctrl   = w_wr & (w_word == c_WORD_CTRL);
    assign w_wr_count  = w_wr & (w_word == c_WORD_COUNT);
    assign w_wr_cmp    = w_wr & (w_word == c_WORD_CMP);
    assign w_wr_status = w_wr & (w_word == c_WORD_STATUS);

    // A CPU load of COUNT suppresses counting and all event detection that cycle.
    assign w_cnt_active = r_ctrl[0] & ~w_wr_count;
    assign w_match      = (r_count == r_compare);
    assign w_count_max  = (r_count == c_COUNT_MAX);
    assign w_hw_set[0]  = w_cnt_active & w_match;
    // Overflow only when the counter actually increments past all-ones;
    // a clear-on-match or stop-on-match takes the place of the increment.
    assign w_hw_set[1]  = w_cnt_active & w_count_max &
                          ~(w_match & (r_ctrl[1] | r_ctrl[2]));

    // Decode access size into a byte-lane mask.
    always_comb begin
        w_bmask = '1;
        case (bus.size)
            2'b00:   w_bmask = 64'h0000_0000_0000_00FF;
            2'b01:   w_bmask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_bmask = 64'h0000_0000_FFFF_FFFF;
            default: w_bmask = '1;
        endcase
    end

    // Read mux: zero-extended register value trimmed to the access size.
    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_WORD_CTRL:   w_rdata = 64'(r_ctrl);
            c_WORD_COUNT:  w_rdata = 64'(r_count);
            c_WORD_CMP:    w_rdata = 64'(r_compare);
            c_WORD_STATUS: w_rdata = 64'(r_status);
            default:       w_rdata = '0;
        endcase
        w_rdata = w_rdata & w_bmask;
    end

    assign data = w_rd_drive ? w_rdata : 64'bz;

    // Counter: CPU load first, otherwise count / clear / hold on match.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= TIMER_SIZE'(f_merge(64'(r_count), data, w_bmask));
        end else if (w_cnt_active) begin
            if (w_match && r_ctrl[1]) begin
                r_count <= '0;
            end else if (!(w_match && r_ctrl[2])) begin
                r_count <= r_count + TIMER_SIZE'(1);
            end
        end
    end

    // Control: CPU write beats the stop-on-match auto-clear of EN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= 3'(f_merge(64'(r_ctrl), data, w_bmask));
        end else if (w_cnt_active && w_match && r_ctrl[2]) begin
            r_ctrl[0] <= 1'b0;
        end
    end

    // Compare register: plain CPU-writable value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_compare <= '0;
        end else if (w_wr_cmp) begin
            r_compare <= TIMER_SIZE'(f_merge(64'(r_compare), data, w_bmask));
        end
    end

    // Status: sticky flags, write-1-to-clear, hardware set wins over clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_status <= '0;
        end else begin
            r_status <= (w_wr_status ? (r_status & ~data[1:0]) : r_status) | w_hw_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_timer
// Description : Bench for mmio_timer. Two instances share one bus: a 32-bit
//               timer at 0x8000_0000 and an 8-bit timer at 0x9000_0000.
//               Reads are compared against a register-level reference model;
//               an undriven data bus floats high through a pull-up.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_timer;

    localparam logic [31:0] c_BASE0   = 32'h8000_0000;
    localparam logic [31:0] c_BASE1   = 32'h9000_0000;
    localparam logic [63:0] c_FLOAT   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        drv_en;
    logic [63:0] drv_val;
    wire  [63:0] data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state per instance (index 0: 32-bit timer, 1: 8-bit timer).
    logic [63:0] m_ctrl  [2];
    logic [63:0] m_count [2];
    logic [63:0] m_cmp   [2];
    logic [63:0] m_stat  [2];

    always #5 clock = ~clock;

    mmio_timer_if bus ();

    assign data = drv_en ? drv_val : 64'bz;
    pullup (data);

    mmio_timer #(.BASE_ADDR(c_BASE0), .ADDR_WIDTH(8), .TIMER_SIZE(32)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .data  (data)
    );

    mmio_timer #(.BASE_ADDR(c_BASE1), .ADDR_WIDTH(8), .TIMER_SIZE(8)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .data  (data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int inst_of(input logic [31:0] addr);
        if (addr[31:8] == c_BASE0[31:8]) return 0;
        if (addr[31:8] == c_BASE1[31:8]) return 1;
        return -1;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] sz);
        return (sz == 2'd3) ? c_FLOAT : ((64'd1 << (8 << sz)) - 64'd1);
    endfunction

    function automatic logic [63:0] max_of(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'hFF;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ctrl[i] = '0; m_count[i] = '0; m_cmp[i] = '0; m_stat[i] = '0;
        end
    endfunction

    function automatic logic [63:0] exp_read(input logic [31:0] addr, input logic [1:0] sz);
        int i;
        logic [63:0] v;
        i = inst_of(addr);
        if (i < 0) return c_FLOAT;
        case (addr[7:3])
            5'd0:    v = m_ctrl[i];
            5'd1:    v = m_count[i];
            5'd2:    v = m_cmp[i];
            5'd3:    v = m_stat[i];
            default: v = '0;
        endcase
        return v & lane_mask(sz);
    endfunction

    // One clock edge of the register-level behaviour for both instances.
    function automatic void model_step(input logic wr, input logic [31:0] addr,
                                       input logic [1:0] sz, input logic [63:0] wd);
        for (int i = 0; i < 2; i++) begin
            logic        hit;
            logic [4:0]  word;
            logic [63:0] mk, mx, merged_cnt;
            logic [63:0] nc, nn, nk, ns;
            logic [1:0]  hw;
            logic        do_inc;
            hit  = wr && (inst_of(addr) == i);
            word = addr[7:3];
            mk   = lane_mask(sz);
            mx   = max_of(i);
            nc = m_ctrl[i]; nn = m_count[i]; nk = m_cmp[i]; ns = m_stat[i];
            hw = 2'b00;
            do_inc = 1'b0;
            merged_cnt = ((m_count[i] & ~mk) | (wd & mk)) & mx;
            if (hit && word == 5'd1) begin
                nn = merged_cnt;
            end else if (m_ctrl[i][0]) begin
                if (m_count[i] == m_cmp[i]) begin
                    hw[0] = 1'b1;
                    if (m_ctrl[i][2]) nc[0] = 1'b0;
                    if (m_ctrl[i][1])      nn = 0;
                    else if (!m_ctrl[i][2]) do_inc = 1'b1;
                end else begin
                    do_inc = 1'b1;
                end
            end
            if (do_inc) begin
                if (m_count[i] == mx) begin
                    nn = 0;
                    hw[1] = 1'b1;
                end else begin
                    nn = m_count[i] + 1;
                end
            end
            if (hit && word == 5'd0) nc = ((m_ctrl[i] & ~mk) | (wd & mk)) & 64'h7;
            if (hit && word == 5'd2) nk = ((m_cmp[i] & ~mk) | (wd & mk)) & mx;
            if (hit && word == 5'd3) ns = m_stat[i] & ~(wd & 64'h3);
            ns = ns | 64'(hw);
            m_ctrl[i] = nc; m_count[i] = nn; m_cmp[i] = nk; m_stat[i] = ns;
        end
    endfunction

    // One bus cycle, entered and left just after a falling edge.
    task automatic bus_cycle(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [1:0] sz, input logic [63:0] wd, input string tag);
        bus.address   = addr;
        bus.mem_write = wr;
        bus.mem_read  = rd;
        bus.size      = sz;
        drv_en        = wr;
        drv_val       = wd;
        #1;
        if (!wr) begin
            if (rd) check(tag, data, exp_read(addr, sz));
            else    check({tag, "_nodrive"}, data, c_FLOAT);
        end
        @(posedge clock);
        model_step(wr, addr, sz, wd);
        @(negedge clock);
    endtask

    task automatic wr8(input logic [31:0] addr, input logic [63:0] wd);
        bus_cycle(1'b1, 1'b0, addr, 2'd3, wd, "wr");
    endtask

    task automatic rd8(input logic [31:0] addr, input string tag);
        bus_cycle(1'b0, 1'b1, addr, 2'd3, 64'd0, tag);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] base;
        logic [7:0]  off;
        case ($urandom_range(0, 9))
            0:       base = 32'h8000_0100;
            1:       base = 32'h7FFF_FF00;
            2, 3, 4: base = c_BASE1;
            default: base = c_BASE0;
        endcase
        if ($urandom_range(0, 7) == 0) off = 8'($urandom);
        else off = {3'b000, 2'($urandom_range(0, 3)), 3'($urandom)};
        return base | {24'd0, off};
    endfunction

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic [63:0] wd;
        int          r;

        reset = 1'b1;
        drv_en = 1'b0; drv_val = '0;
        bus.address = '0; bus.mem_write = 1'b0; bus.mem_read = 1'b0; bus.size = 2'd3;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state and idle bus
        bus_cycle(1'b0, 1'b0, c_BASE0, 2'd3, 64'd0, "idle");
        check("rst_count_const", data, c_FLOAT);
        for (int k = 0; k < 4; k++) begin
            rd8(c_BASE0 + 32'(8 * k), "rst_reg0");
            rd8(c_BASE1 + 32'(8 * k), "rst_reg1");
        end

        // Enable and watch the count advance
        wr8(c_BASE0, 64'h1);
        rd8(c_BASE0, "ctrl_en");
        repeat (4) rd8(c_BASE0 + 8, "count_run");

        // Clear-on-match with W1C of MATCH
        wr8(c_BASE0, 64'h0);
        wr8(c_BASE0 + 8, 64'h0);
        wr8(c_BASE0 + 32'h10, 64'h5);
        wr8(c_BASE0, 64'h3);
        repeat (9) rd8(c_BASE0 + 8, "clr_match_cnt");
        rd8(c_BASE0 + 32'h18, "match_set");
        wr8(c_BASE0 + 32'h18, 64'h1);
        rd8(c_BASE0 + 32'h18, "match_w1c");
        repeat (6) rd8(c_BASE0 + 32'h18, "match_again");

        // Overflow on the 8-bit instance and narrow reads
        wr8(c_BASE1 + 8, 64'hFE);
        wr8(c_BASE1, 64'h1);
        repeat (3) rd8(c_BASE1 + 8, "ovf_cnt");
        rd8(c_BASE1 + 32'h18, "ovf_status");
        bus_cycle(1'b0, 1'b1, c_BASE0 + 8, 2'd0, 64'd0, "count_byte0");
        bus_cycle(1'b0, 1'b1, c_BASE0 + 8, 2'd1, 64'd0, "count_half");

        // Stop-on-match, then a COUNT write beating the increment
        wr8(c_BASE0, 64'h0);
        wr8(c_BASE0 + 8, 64'h0);
        wr8(c_BASE0 + 32'h18, 64'h3);
        wr8(c_BASE0 + 32'h10, 64'h3);
        wr8(c_BASE0, 64'h5);
        repeat (6) rd8(c_BASE0 + 8, "stop_cnt");
        rd8(c_BASE0, "stop_ctrl");
        wr8(c_BASE0, 64'h1);
        wr8(c_BASE0 + 8, 64'h10);
        repeat (3) rd8(c_BASE0 + 8, "load_wins");

        // Accesses outside the window have no effect
        bus_cycle(1'b1, 1'b0, 32'h8000_0100, 2'd3, 64'h77, "wr_out");
        bus_cycle(1'b1, 1'b0, 32'h7FFF_FFF8, 2'd3, 64'h77, "wr_out");
        rd8(32'h8000_0100, "rd_out_hi");
        rd8(32'h7FFF_FFF8, "rd_out_lo");
        rd8(c_BASE0 + 32'h10, "cmp_kept");

        // Asynchronous reset between clock edges
        wr8(c_BASE1, 64'h1);
        repeat (3) rd8(c_BASE0 + 8, "pre_reset");
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            rd8(c_BASE0 + 32'(8 * k), "async_rst0");
            rd8(c_BASE1 + 32'(8 * k), "async_rst1");
        end

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r  = $urandom_range(0, 99);
            a  = pick_addr();
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) wd = {$urandom, $urandom};
            else                           wd = 64'($urandom_range(0, 15));
            if (r < 40)      bus_cycle(1'b0, 1'b1, a, sz, 64'd0, "rnd_rd");
            else if (r < 65) bus_cycle(1'b1, 1'($urandom_range(0, 1)), a, sz, wd, "rnd_wr");
            else             bus_cycle(1'b0, 1'b0, a, sz, 64'd0, "rnd_idle");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
